// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_driver: multiplexes packed BCD digits onto a common-anode         |
// | 7-segment display with per-slot dead time and leading-zero blanking.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  input  logic                      lz_blank_i,
  output logic [NUM_DIGITS-1:0]     an_o,
  output logic [6:0]                seg_o,
  output logic                      dp_o
);

  localparam int SLOT  = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic             OFF        = (ACTIVE_LOW != 0);

  if (SLOT <= BLANK_CYCLES + 1) begin : g_bad_slot
    $error("seg7_scan_driver: SLOT must exceed BLANK_CYCLES+1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg7_scan_driver: BLANK_CYCLES must be at least 1");
  end
  if ((NUM_DIGITS < 2) || (NUM_DIGITS > 8)) begin : g_bad_digits
    $error("seg7_scan_driver: NUM_DIGITS must be in 2..8");
  end

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              digit_q, digit_d;
  logic                    dp_lat_q, dp_lat_d;
  logic                    blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;

  logic [NUM_DIGITS-1:0]   digit_zero;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [3:0]              sel_digit;
  logic                    sel_dp;
  logic                    sel_upper_zero;
  logic                    blank_now;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [6:0]              seg_act;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // upper_zero[k]: digit k and every digit above it read zero
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_zero
    assign digit_zero[k] = (digits_i[4*k +: 4] == 4'd0);
    assign upper_zero[k] = &digit_zero[NUM_DIGITS-1:k];
  end

  always_comb begin
    sel_digit      = 4'd0;
    sel_dp         = 1'b0;
    sel_upper_zero = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_digit      = digits_i[4*k +: 4];
        sel_dp         = dp_i[k];
        sel_upper_zero = upper_zero[k];
      end
    end
  end

  assign blank_now = lz_blank_i && (idx_q != '0) && sel_upper_zero;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    digit_d  = digit_q;
    dp_lat_d = dp_lat_q;
    blank_d  = blank_q;
    if (!en_i) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      case (state_q)
        ST_BLANK: begin
          // Capture once per slot so mid-slot input changes cannot tear the digit
          if (cnt_q == SAMPLE_CNT) begin
            digit_d  = sel_digit;
            dp_lat_d = sel_dp;
            blank_d  = blank_now;
            state_d  = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_BLANK;
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  // Output registers are loaded from next-state so pins line up with state_q
  always_comb begin
    an_act  = '0;
    seg_act = 7'h00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_act[k] = (idx_d == IDX_W'(k));
    end
    seg_act = blank_d ? 7'h00 : bcd_to_seg(digit_d);
    an_d    = {NUM_DIGITS{OFF}};
    seg_d   = {7{OFF}};
    dpo_d   = OFF;
    if (state_d == ST_SHOW) begin
      an_d  = an_act ^ {NUM_DIGITS{OFF}};
      seg_d = seg_act ^ {7{OFF}};
      dpo_d = dp_lat_d ^ OFF;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      digit_q  <= 4'd0;
      dp_lat_q <= 1'b0;
      blank_q  <= 1'b0;
      an_q     <= {NUM_DIGITS{OFF}};
      seg_q    <= {7{OFF}};
      dpo_q    <= OFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      digit_q  <= digit_d;
      dp_lat_q <= dp_lat_d;
      blank_q  <= blank_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dpo_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver.                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_driver;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int ND    = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        lz_blank_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  seg7_scan_driver #(
    .CLK_FREQ_HZ (1000),
    .SCAN_HZ     (100),
    .NUM_DIGITS  (ND),
    .BLANK_CYCLES(BLANK),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .digits_i   (digits_i),
    .dp_i       (dp_i),
    .lz_blank_i (lz_blank_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o)
  );

  always #5 clk_i = ~clk_i;

  logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [11:0] exp_q [$];

  // Reference model: m_t counts clock edges since the scan (re)started
  int         m_t = 0;
  logic [3:0] m_dig = 4'd0;
  logic       m_dp  = 1'b0;
  logic       m_blk = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [11:0] e;
    int ph;
    int d;
    logic show;
    if (!rst_ni || !en_i) begin
      m_t = 0;
      e   = 12'hFFF;
    end else begin
      ph = m_t % SLOT;
      d  = (m_t / SLOT) % ND;
      if (ph == BLANK - 1) begin
        m_dig = digits_i[4*d +: 4];
        m_dp  = dp_i[d];
        m_blk = lz_blank_i && (d > 0) && ((digits_i >> (4*d)) == 16'd0);
      end
      show = (ph >= BLANK - 1) && (ph < SLOT - 1);
      m_t++;
      e = show ? {~(4'b0001 << d), (m_blk ? 7'h7F : ~seg_tab[m_dig]), ~m_dp} : 12'hFFF;
    end
    @(posedge clk_i);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic seek(input string tag, input int ph, input int dg);
    int i;
    for (i = 0; i < 200; i++) begin
      if ((m_t % SLOT == ph) && ((m_t / SLOT) % ND == dg)) break;
      cycle();
    end
    check(tag, (i < 200) ? 32'd1 : 32'd0, 32'd1);
  endtask

  always @(negedge clk_i) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_pops++;
      check("scan", {20'd0, an_o, seg_o, dp_o}, {20'd0, e});
    end
  end

  initial begin
    rst_ni     = 1'b0;
    en_i       = 1'b0;
    digits_i   = 16'h0000;
    dp_i       = 4'b0000;
    lz_blank_i = 1'b0;
    repeat (3) cycle();
    check("reset_out", {an_o, seg_o, dp_o}, 12'hFFF);

    // Scan order
    rst_ni   = 1'b1;
    en_i     = 1'b1;
    digits_i = 16'h1234;
    cycle();
    check("first_blank", an_o, 4'b1111);
    cycle();
    check("first_an", an_o, 4'b1110);
    check("first_seg", {25'd0, ~seg_o}, 32'h66);
    repeat (4*SLOT - 2) cycle();

    // Leading zeros with and without blanking
    digits_i   = 16'h0007;
    lz_blank_i = 1'b1;
    repeat (4*SLOT) cycle();
    lz_blank_i = 1'b0;
    repeat (4*SLOT) cycle();

    // Non-BCD and decimal point
    digits_i = 16'hA905;
    dp_i     = 4'b0100;
    repeat (4*SLOT) cycle();
    lz_blank_i = 1'b1;
    repeat (4*SLOT) cycle();

    // No tearing
    digits_i   = 16'h1233;
    dp_i       = 4'b0000;
    lz_blank_i = 1'b0;
    seek("seek_tear", 5, 0);
    digits_i = 16'h1238;
    repeat (4) cycle();
    check("tear_an", an_o, 4'b1110);
    check("tear_hold", {25'd0, ~seg_o}, 32'h4F);
    repeat (3*SLOT + 4) cycle();
    check("tear_next_an", an_o, 4'b1110);
    check("tear_next", {25'd0, ~seg_o}, 32'h7F);

    // Asynchronous reset during digit 2 SHOW
    seek("seek_rst", 4, 2);
    check("pre_rst_an", an_o, 4'b1011);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst", {an_o, seg_o, dp_o}, 12'hFFF);
    repeat (3) cycle();
    rst_ni = 1'b1;
    cycle();
    check("rst_blank", an_o, 4'b1111);
    cycle();
    check("rst_digit0", an_o, 4'b1110);
    repeat (2*SLOT) cycle();

    // Enable drop mid-slot
    seek("seek_en", 6, 1);
    en_i = 1'b0;
    cycle();
    check("en_off", {an_o, seg_o, dp_o}, 12'hFFF);
    repeat (6) cycle();
    en_i = 1'b1;
    cycle();
    check("en_blank", an_o, 4'b1111);
    cycle();
    check("en_digit0", an_o, 4'b1110);
    repeat (2*SLOT) cycle();

    @(negedge clk_i);
    #1;
    check("drain", exp_q.size(), 32'd0);
    check("pops", (n_pops > 300) ? 32'd1 : 32'd0, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
